// File: rtl/trade_frame_latch_pkg.sv
// Shared types and constants for the trade frame latch: FSM encoding, snapshot
// position defaults, trade side codes and bus payloads.
package trade_frame_latch_pkg;

    localparam int unsigned PRICE_W    = 8;
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned V_SNAP_DEF = 480;
    localparam int unsigned H_SNAP_DEF = 0;

    localparam logic               SIDE_BUY  = 1'b0;
    localparam logic               SIDE_SELL = 1'b1;
    localparam logic [PRICE_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_HALT        = 2'd1,
        ST_RESUME_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic               side;
        logic [PRICE_W-1:0] price;
    } trade_t;

    typedef struct packed {
        logic [PRICE_W-1:0] buy;
        logic [PRICE_W-1:0] sell;
        logic [PRICE_W-1:0] count;
        logic [PRICE_W-1:0] spread;
    } frame_t;

endpackage

// File: rtl/trade_frame_latch_spread_guard.sv
// Clamped sell-minus-buy spread of the shadow prices and the over-limit flag
// that forces the latch into HALT.
module trade_frame_latch_spread_guard
    import trade_frame_latch_pkg::*;
#(
    parameter logic [PRICE_W-1:0] LIMIT = 8'd100
) (
    input  logic [PRICE_W-1:0] buy,
    input  logic [PRICE_W-1:0] sell,
    output logic [PRICE_W-1:0] spread_c,
    output logic               over_limit_c
);

    // Inverted markets read as zero spread rather than wrapping.
    always_comb begin
        spread_c = '0;
        if (sell >= buy) begin
            spread_c = sell - buy;
        end
        over_limit_c = (spread_c > LIMIT);
    end

endmodule

// File: rtl/trade_frame_latch.sv
// Collects trade events into shadow registers and republishes them to the
// display once per frame; halts trading on request or on an excessive spread.
module trade_frame_latch
    import trade_frame_latch_pkg::*;
#(
    parameter int unsigned        V_SNAP       = V_SNAP_DEF,
    parameter int unsigned        H_SNAP       = H_SNAP_DEF,
    parameter logic [PRICE_W-1:0] SPREAD_LIMIT = 8'd100
) (
    input  logic               clk_25mhz,
    input  logic               rst,
    input  logic [CNT_W-1:0]   h_cnt,
    input  logic [CNT_W-1:0]   v_cnt,
    input  logic               trade_valid,
    output logic               trade_ready,
    input  logic               trade_side,
    input  logic [PRICE_W-1:0] trade_price,
    input  logic               halt_req,
    input  logic               halt_clear,
    output logic [PRICE_W-1:0] buy_price,
    output logic [PRICE_W-1:0] sell_price,
    output logic [PRICE_W-1:0] trade_count,
    output logic [PRICE_W-1:0] spread,
    output logic               halt_signal,
    output logic               frame_tick
);

    state_t             state_q, state_d;
    logic               ready_d, halt_d, clear_count_c;
    trade_t             trade_c;
    logic               accept_c, snap_c;
    logic [PRICE_W-1:0] shadow_buy, shadow_sell, shadow_count;
    logic [PRICE_W-1:0] shadow_spread_c;
    logic               over_limit_c;
    frame_t             frame_q;

    assign trade_c  = '{side: trade_side, price: trade_price};
    assign accept_c = trade_valid && trade_ready;
    assign snap_c   = (h_cnt == CNT_W'(H_SNAP)) && (v_cnt == CNT_W'(V_SNAP));

    trade_frame_latch_spread_guard #(
        .LIMIT        (SPREAD_LIMIT)
    ) spread_guard (
        .buy          (shadow_buy),
        .sell         (shadow_sell),
        .spread_c     (shadow_spread_c),
        .over_limit_c (over_limit_c)
    );

    // Ready and halt are registered from the next state so they switch on the
    // same edge as the FSM; leaving RESUME_WAIT lines up with frame_tick.
    always_comb begin
        state_d       = state_q;
        clear_count_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt_req || over_limit_c) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (halt_clear && !halt_req) begin
                    state_d       = ST_RESUME_WAIT;
                    clear_count_c = 1'b1;
                end
            end
            ST_RESUME_WAIT: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (snap_c) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        ready_d = (state_d == ST_RUN);
        halt_d  = (state_d != ST_RUN);
    end

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            trade_ready <= 1'b0;
            halt_signal <= 1'b0;
        end else begin
            state_q     <= state_d;
            trade_ready <= ready_d;
            halt_signal <= halt_d;
        end
    end

    // Shadow registers follow accepted trades cycle by cycle.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            shadow_buy   <= '0;
            shadow_sell  <= '0;
            shadow_count <= '0;
        end else begin
            if (accept_c && trade_c.side == SIDE_SELL) begin
                shadow_sell <= trade_c.price;
            end else if (accept_c && trade_c.side == SIDE_BUY) begin
                shadow_buy <= trade_c.price;
            end
            if (clear_count_c) begin
                shadow_count <= '0;
            end else if (accept_c && shadow_count != COUNT_MAX) begin
                shadow_count <= shadow_count + PRICE_W'(1);
            end
        end
    end

    // Snapshot takes pre-update shadow values, so a same-cycle trade waits a frame.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            frame_q    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= snap_c;
            if (snap_c) begin
                frame_q <= '{buy:    shadow_buy,
                             sell:   shadow_sell,
                             count:  shadow_count,
                             spread: shadow_spread_c};
            end
        end
    end

    assign buy_price   = frame_q.buy;
    assign sell_price  = frame_q.sell;
    assign trade_count = frame_q.count;
    assign spread      = frame_q.spread;

endmodule

// File: tb/tb_trade_frame_latch.sv
// Self-checking bench for trade_frame_latch: table-driven trade vectors plus
// hand sequences for saturation, spread halt, resume and mid-halt reset.
module tb_trade_frame_latch;
    import trade_frame_latch_pkg::*;

    logic       clk_25mhz = 1'b0;
    logic       rst;
    logic [9:0] h_cnt, v_cnt;
    logic       trade_valid, trade_ready, trade_side;
    logic [7:0] trade_price;
    logic       halt_req, halt_clear;
    logic [7:0] buy_price, sell_price, trade_count, spread;
    logic       halt_signal, frame_tick;

    trade_frame_latch dut (
        .clk_25mhz   (clk_25mhz),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .trade_valid (trade_valid),
        .trade_ready (trade_ready),
        .trade_side  (trade_side),
        .trade_price (trade_price),
        .halt_req    (halt_req),
        .halt_clear  (halt_clear),
        .buy_price   (buy_price),
        .sell_price  (sell_price),
        .trade_count (trade_count),
        .spread      (spread),
        .halt_signal (halt_signal),
        .frame_tick  (frame_tick)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    typedef struct packed {
        logic [7:0] buy;
        logic [7:0] sell;
        logic [7:0] count;
        logic [7:0] spread;
    } snap_t;

    typedef struct {
        logic       v;
        logic       side;
        logic [7:0] price;
        logic       snap;
        logic       exp_ready;
    } vec_t;

    int    n_vec = 0;
    int    n_bad = 0;
    snap_t exp_q[$];
    snap_t disp_exp;
    logic [7:0] m_buy, m_sell, m_count;
    vec_t  tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.buy    = m_buy;
        s.sell   = m_sell;
        s.count  = m_count;
        s.spread = (m_sell >= m_buy) ? m_sell - m_buy : 8'd0;
        return s;
    endfunction

    task automatic observe();
        snap_t e;
        if (frame_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame_tick", 32'(frame_tick), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("snap_buy",    32'(buy_price),   32'(e.buy));
                chk("snap_sell",   32'(sell_price),  32'(e.sell));
                chk("snap_count",  32'(trade_count), 32'(e.count));
                chk("snap_spread", 32'(spread),      32'(e.spread));
                disp_exp = e;
            end
        end else begin
            chk("display_hold", {buy_price, sell_price, trade_count, spread}, 32'(disp_exp));
        end
    endtask

    task automatic cyc(input logic v, input logic side, input logic [7:0] price, input logic snap);
        trade_valid = v;
        trade_side  = side;
        trade_price = price;
        h_cnt       = snap ? 10'd0   : 10'd5;
        v_cnt       = snap ? 10'd480 : 10'd5;
        if (snap) exp_q.push_back(model_snap());
        if (v) begin
            if (side == SIDE_SELL) m_sell = price;
            else                   m_buy  = price;
            if (m_count != 8'hFF) m_count = m_count + 8'd1;
        end
        @(posedge clk_25mhz);
        #1;
        trade_valid = 1'b0;
        h_cnt       = 10'd5;
        v_cnt       = 10'd5;
        observe();
        if (snap) chk("frame_tick_missing", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, SIDE_BUY, 8'd0, 1'b0);
    endtask

    task automatic check_zero(input string name);
        chk(name, {buy_price, sell_price, trade_count, spread}, 32'd0);
        chk({name, "_flags"}, {29'd0, halt_signal, frame_tick, trade_ready}, 32'd0);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, then releases.
    task automatic do_reset();
        #5 rst = 1'b1;
        m_buy = 8'd0; m_sell = 8'd0; m_count = 8'd0;
        exp_q.delete();
        disp_exp = '0;
        #2 check_zero("reset_async");
        @(posedge clk_25mhz); #1;
        @(posedge clk_25mhz); #1;
        check_zero("reset_held");
        rst = 1'b0;
        idle(1);
        chk("ready_after_reset", 32'(trade_ready), 32'd1);
        chk("halt_after_reset",  32'(halt_signal), 32'd0);
    endtask

    initial begin
        rst = 1'b0; h_cnt = 10'd5; v_cnt = 10'd5;
        trade_valid = 1'b0; trade_side = SIDE_BUY; trade_price = 8'd0;
        halt_req = 1'b0; halt_clear = 1'b0;
        m_buy = 8'd0; m_sell = 8'd0; m_count = 8'd0; disp_exp = '0;

        tbl[0]  = '{1'b1, SIDE_BUY,  8'd40, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, SIDE_BUY,  8'd0,  1'b0, 1'b1};
        tbl[2]  = '{1'b1, SIDE_SELL, 8'd60, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, SIDE_BUY,  8'd0,  1'b0, 1'b1};
        tbl[4]  = '{1'b0, SIDE_BUY,  8'd0,  1'b1, 1'b1};
        tbl[5]  = '{1'b0, SIDE_BUY,  8'd0,  1'b0, 1'b1};
        tbl[6]  = '{1'b1, SIDE_SELL, 8'd30, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, SIDE_BUY,  8'd0,  1'b0, 1'b1};
        tbl[8]  = '{1'b0, SIDE_BUY,  8'd0,  1'b1, 1'b1};
        tbl[9]  = '{1'b1, SIDE_BUY,  8'd10, 1'b0, 1'b1};
        tbl[10] = '{1'b0, SIDE_BUY,  8'd0,  1'b1, 1'b1};
        tbl[11] = '{1'b0, SIDE_BUY,  8'd0,  1'b0, 1'b1};

        @(posedge clk_25mhz); #1;
        do_reset();

        // Buy 40 / sell 60, snapshot, same-cycle sell 30, inverted spread.
        for (int i = 0; i < 12; i++) begin
            chk("table_ready", 32'(trade_ready), 32'(tbl[i].exp_ready));
            cyc(tbl[i].v, tbl[i].side, tbl[i].price, tbl[i].snap);
        end

        // Count saturation.
        do_reset();
        for (int i = 0; i < 300; i++)
            cyc(1'b1, (i % 2 == 1) ? SIDE_SELL : SIDE_BUY, (i % 2 == 1) ? 8'd20 : 8'd10, 1'b0);
        cyc(1'b0, SIDE_BUY, 8'd0, 1'b1);
        chk("count_saturated", 32'(trade_count), 32'd255);

        // Spread breach halts without waiting for a frame.
        do_reset();
        cyc(1'b1, SIDE_BUY,  8'd50, 1'b0);
        cyc(1'b1, SIDE_SELL, 8'd20, 1'b0);
        cyc(1'b0, SIDE_BUY,  8'd0,  1'b1);
        chk("inverted_spread", 32'(spread), 32'd0);
        cyc(1'b1, SIDE_SELL, 8'd200, 1'b0);
        chk("ready_on_accept", 32'(trade_ready), 32'd1);
        idle(1);
        chk("spread_halt_ready", 32'(trade_ready), 32'd0);
        chk("spread_halt_sig",   32'(halt_signal), 32'd1);
        idle(3);
        chk("spread_halt_held",  32'(halt_signal), 32'd1);

        // External halt, ignored clear, then resume aligned to the frame.
        do_reset();
        cyc(1'b1, SIDE_BUY,  8'd5, 1'b0);
        cyc(1'b1, SIDE_SELL, 8'd7, 1'b0);
        cyc(1'b0, SIDE_BUY,  8'd0, 1'b1);
        halt_req = 1'b1;
        idle(1);
        chk("halt_req_ready", 32'(trade_ready), 32'd0);
        chk("halt_req_sig",   32'(halt_signal), 32'd1);
        halt_clear = 1'b1;
        idle(1);
        halt_clear = 1'b0;
        idle(1);
        halt_req = 1'b0;
        idle(2);
        chk("clear_ignored_sig",   32'(halt_signal), 32'd1);
        chk("clear_ignored_ready", 32'(trade_ready), 32'd0);
        halt_clear = 1'b1;
        m_count = 8'd0;
        idle(1);
        halt_clear = 1'b0;
        idle(3);
        chk("resume_wait_sig",   32'(halt_signal), 32'd1);
        chk("resume_wait_ready", 32'(trade_ready), 32'd0);
        cyc(1'b0, SIDE_BUY, 8'd0, 1'b1);
        chk("resume_sig",   32'(halt_signal), 32'd0);
        chk("resume_ready", 32'(trade_ready), 32'd1);
        chk("resume_count", 32'(trade_count), 32'd0);

        // Reset from RESUME_WAIT discards everything.
        halt_req = 1'b1;
        idle(1);
        halt_req = 1'b0;
        halt_clear = 1'b1;
        idle(1);
        halt_clear = 1'b0;
        idle(1);
        chk("pre_reset_resume_wait", 32'(halt_signal), 32'd1);
        do_reset();
        cyc(1'b1, SIDE_BUY, 8'd9, 1'b0);
        cyc(1'b0, SIDE_BUY, 8'd0, 1'b1);
        idle(2);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/trade_frame_latch.md
TRADE_FRAME_LATCH -- requirements
Module: trade_frame_latch

Interface
REQ-001 Parameter V_SNAP, 480: v_cnt value at which the frame snapshot is taken (first blanking line).
REQ-002 Parameter H_SNAP, 0: h_cnt value at which the frame snapshot is taken.
REQ-003 Parameter SPREAD_LIMIT, 8'd100: shadow spread strictly above this value forces HALT.
REQ-004 clk_25mhz  in  1  pixel clock; the only clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 h_cnt  in  10  horizontal pixel counter from the timing generator.
REQ-007 v_cnt  in  10  vertical line counter from the timing generator.
REQ-008 trade_valid  in  1  trade event offered.
REQ-009 trade_ready  out  1  trade event may be accepted.
REQ-010 trade_side  in  1  0 = buy, 1 = sell; qualified by trade_valid.
REQ-011 trade_price  in  8  executed price; qualified by trade_valid.
REQ-012 halt_req  in  1  external halt request, level.
REQ-013 halt_clear  in  1  operator resume, single-cycle pulse.
REQ-014 buy_price / sell_price / trade_count / spread  out  8 each  frame-stable values for vga_display.
REQ-015 halt_signal  out  1  display halt indication.
REQ-016 frame_tick  out  1  one-cycle pulse, asserted in the cycle the display outputs update.

Function
REQ-017 Accept = trade_valid && trade_ready; at most one trade per cycle; no data is held across a non-accept.
REQ-018 An accepted buy SHALL load shadow_buy; an accepted sell SHALL load shadow_sell; each accept SHALL increment shadow_count, saturating at 255.
REQ-019 shadow_spread SHALL be shadow_sell - shadow_buy when sell >= buy, else 0, computed combinationally from the shadow registers, 8 bits, no wrap.
REQ-020 Snapshot condition: h_cnt == H_SNAP && v_cnt == V_SNAP in a cycle; frame_tick SHALL be high in the next cycle, and the four 8-bit outputs SHALL hold the shadow values from the condition cycle from that cycle onward.
REQ-021 A trade accepted in the snapshot-condition cycle SHALL NOT appear in that snapshot; it SHALL appear at the following snapshot.
REQ-022 Between snapshots, the display outputs SHALL NOT change.
REQ-023 FSM states: RUN, HALT, RESUME_WAIT.
REQ-024 RUN: trade_ready = 1; go to HALT when halt_req = 1, or when shadow_spread > SPREAD_LIMIT.
REQ-025 HALT: trade_ready = 0; halt_signal = 1 from the cycle after entry, not frame-aligned; halt_clear with halt_req = 0 SHALL go to RESUME_WAIT and clear shadow_count to 0.
REQ-026 HALT: halt_clear while halt_req = 1 SHALL be ignored.
REQ-027 RESUME_WAIT: trade_ready = 0; halt_signal stays 1; on the snapshot condition, go to RUN, and halt_signal SHALL drop in the same cycle frame_tick asserts.
REQ-028 RESUME_WAIT: halt_req = 1 SHALL return the FSM to HALT.
REQ-029 The spread-limit check SHALL use shadow values, so a breaching trade halts one cycle after acceptance, independent of the frame.
REQ-030 In RUN, simultaneous halt_req and accept SHALL accept the trade and then enter HALT.

Reset
REQ-031 While rst is high: all shadow registers and display outputs = 0, halt_signal = 0, frame_tick = 0, trade_ready = 0, FSM = RUN.
REQ-032 trade_ready SHALL be 1 from the first clk_25mhz edge after rst deasserts.
REQ-033 rst mid-frame or mid-HALT SHALL discard all pending shadow data; the first post-reset snapshot SHALL show zeros plus any trades accepted after reset.

Structure
REQ-034 Shared package holds the FSM state encoding, V_SNAP/H_SNAP defaults, and the SIDE_BUY/SIDE_SELL constants.
REQ-035 One sub-module, spread_guard, SHALL compute the clamped spread and the over-limit flag from the two shadow prices.

Verification
REQ-036 Reset, then buy 40, then sell 60 mid-frame: outputs stay 0 until snapshot; after frame_tick, buy=40, sell=60, spread=20, count=2.
REQ-037 Sell 30 accepted in the snapshot-condition cycle: it is absent from that frame and present at the next frame_tick.
REQ-038 300 accepted trades: trade_count = 255 at the next frame_tick.
REQ-039 Buy 50, sell 20: spread = 0. Then sell 200: HALT entered, trade_ready = 0 and halt_signal = 1 within 2 cycles, before any frame_tick.
REQ-040 halt_req high, halt_clear pulsed: stays HALT. halt_req low, halt_clear pulsed: halt_signal stays 1 until the next frame_tick, then drops with count = 0.
REQ-041 rst asserted in RESUME_WAIT: all outputs 0 immediately, FSM = RUN, trade_ready = 1 after release.
